// File: rtl/rpi_irq_pkg.sv
// rtl/rpi_irq_pkg.sv - shared types, defaults and derived timing constants for rpi_irq_sched
//
// Contents:
//   sched_state_t          scheduler state (idle, burst, gap)
//   DEF_*                  default parameter values
//   cyc_per_bit/word       derived timing helpers
//   burst_len              cycles per burst (L)
//   DEF_CYC_PER_BIT/WORD   derived constants at the default parameters
//   DEF_BURST_LEN          L at the default parameters

package rpi_irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } sched_state_t;

    localparam int DEF_WORD_BITS   = 32;
    localparam int DEF_BURST_WORDS = 4;
    localparam int DEF_HALF_PERIOD = 16;
    localparam int DEF_LEVEL_W     = 8;
    localparam int DEF_GAP_CYCLES  = 64;

    // One RPi clock period (two half-periods) carries one bit.
    function automatic int cyc_per_bit(input int half_period);
        return 2 * half_period;
    endfunction

    function automatic int cyc_per_word(input int word_bits, input int half_period);
        return word_bits * cyc_per_bit(half_period);
    endfunction

    function automatic int burst_len(input int burst_words, input int word_bits,
                                     input int half_period);
        return burst_words * cyc_per_word(word_bits, half_period);
    endfunction

    localparam int DEF_CYC_PER_BIT  = cyc_per_bit(DEF_HALF_PERIOD);
    localparam int DEF_CYC_PER_WORD = cyc_per_word(DEF_WORD_BITS, DEF_HALF_PERIOD);
    localparam int DEF_BURST_LEN    = burst_len(DEF_BURST_WORDS, DEF_WORD_BITS, DEF_HALF_PERIOD);

endpackage

// File: rtl/rpi_irq_sched_arb.sv
// rtl/rpi_irq_sched_arb.sv - two-way round-robin arbiter (module rr_arb2)
//
// Ports:
//   clk_in         system clock
//   rst_n          synchronous active-low reset
//   i_req[1:0]     request per source
//   i_grant_en     commit the current grant into the last-grant register
//   o_grant_valid  at least one request present
//   o_grant_idx    index of the winning source

module rr_arb2 (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_grant_en,
    output logic       o_grant_valid,
    output logic       o_grant_idx
);

    // Resets to 1 so that source 0 wins the first tie.
    logic r_last;

    always_comb begin
        o_grant_valid = |i_req;
        if (i_req == 2'b11) begin
            o_grant_idx = ~r_last;
        end else begin
            o_grant_idx = i_req[1];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (i_grant_en && o_grant_valid) begin
            r_last <= o_grant_idx;
        end
    end

endmodule

// File: rtl/rpi_irq_sched.sv
// rtl/rpi_irq_sched.sv - burst scheduler sharing the RPi interrupt/clock link between two sources
//
// Optional feature: define RPI_IRQ_SCHED_OVF_EN to add the sticky ovf[1:0] port and its logic.
//
// Ports:
//   clk_in            system clock (sole clock)
//   rst_n             synchronous active-low reset
//   ch0_level         source 0 FIFO fill level
//   ch1_level         source 1 FIFO fill level
//   abort_req         cut the current burst short
//   interrupt_enable  high for the whole burst, to the interrupt-clock generator
//   ch_sel            granted source, held through burst and gap
//   ch_pop[1:0]       one-cycle pop strobe per source at each word start
//   bit_idx           current serializer bit, MSB first
//   busy              high during burst or gap
//   aborted           one-cycle pulse when a burst is cut short
//   ovf[1:0]          sticky level-saturation flags (RPI_IRQ_SCHED_OVF_EN only)

module rpi_irq_sched
    import rpi_irq_pkg::*;
#(
    parameter int WORD_BITS   = DEF_WORD_BITS,
    parameter int BURST_WORDS = DEF_BURST_WORDS,
    parameter int HALF_PERIOD = DEF_HALF_PERIOD,
    parameter int LEVEL_W     = DEF_LEVEL_W,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic                         clk_in,
    input  logic                         rst_n,
    input  logic [LEVEL_W-1:0]           ch0_level,
    input  logic [LEVEL_W-1:0]           ch1_level,
    input  logic                         abort_req,
    output logic                         interrupt_enable,
    output logic                         ch_sel,
    output logic [1:0]                   ch_pop,
    output logic [$clog2(WORD_BITS)-1:0] bit_idx,
    output logic                         busy,
    output logic                         aborted
`ifdef RPI_IRQ_SCHED_OVF_EN
    ,
    output logic [1:0]                   ovf
`endif
);

    localparam int CPB       = cyc_per_bit(HALF_PERIOD);
    localparam int BURST_LEN = burst_len(BURST_WORDS, WORD_BITS, HALF_PERIOD);
    localparam int CNT_W     = $clog2(BURST_LEN + 1);
    localparam int GAP_W     = $clog2(GAP_CYCLES + 1);
    localparam int BCYC_W    = $clog2(CPB);
    localparam int WORD_W    = $clog2(BURST_WORDS + 1);
    localparam int IDX_W     = $clog2(WORD_BITS);

    localparam logic [CNT_W-1:0]  BURST_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [BCYC_W-1:0] BCYC_LAST  = BCYC_W'(CPB - 1);
    localparam logic [WORD_W-1:0] WORD_LAST  = WORD_W'(BURST_WORDS - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX    = IDX_W'(WORD_BITS - 1);

    sched_state_t        r_state;
    logic [CNT_W-1:0]    r_burst_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [BCYC_W-1:0]   r_bit_cyc;
    logic [WORD_W-1:0]   r_word_cnt;
    logic [IDX_W-1:0]    r_bit_idx;
    logic                r_ie;
    logic                r_sel;
    logic [1:0]          r_pop;
    logic                r_busy;
    logic                r_aborted;

    logic [1:0]          w_elig;
    logic                w_grant_valid;
    logic                w_grant_idx;
    logic                w_in_idle;
    logic                w_last_cycle;
    logic                w_bit_wrap;
    logic                w_word_wrap;

    assign w_in_idle    = (r_state == ST_IDLE);
    assign w_elig[0]    = (ch0_level >= LEVEL_W'(BURST_WORDS));
    assign w_elig[1]    = (ch1_level >= LEVEL_W'(BURST_WORDS));
    assign w_last_cycle = (r_burst_cnt == BURST_LAST);
    assign w_bit_wrap   = (r_bit_cyc == BCYC_LAST);
    assign w_word_wrap  = w_bit_wrap && (r_bit_idx == '0);

    // Levels only matter in IDLE; the last-grant register moves only on a real grant.
    rr_arb2 u_arb (
        .clk_in        (clk_in),
        .rst_n         (rst_n),
        .i_req         (w_elig),
        .i_grant_en    (w_in_idle),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_burst_cnt <= '0;
            r_gap_cnt   <= '0;
            r_bit_cyc   <= '0;
            r_word_cnt  <= '0;
            r_bit_idx   <= IDX_MAX;
            r_ie        <= 1'b0;
            r_sel       <= 1'b0;
            r_pop       <= 2'b00;
            r_busy      <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_pop     <= 2'b00;
            r_aborted <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        // First burst cycle already carries the word-0 pop.
                        r_state     <= ST_BURST;
                        r_ie        <= 1'b1;
                        r_busy      <= 1'b1;
                        r_sel       <= w_grant_idx;
                        r_pop       <= w_grant_idx ? 2'b10 : 2'b01;
                        r_burst_cnt <= '0;
                        r_bit_cyc   <= '0;
                        r_word_cnt  <= '0;
                        r_bit_idx   <= IDX_MAX;
                    end
                end
                ST_BURST: begin
                    if (w_last_cycle) begin
                        // Abort on the final cycle is just a normal completion.
                        r_state   <= ST_GAP;
                        r_ie      <= 1'b0;
                        r_gap_cnt <= '0;
                        r_bit_cyc <= '0;
                        r_bit_idx <= IDX_MAX;
                    end else if (abort_req) begin
                        r_state   <= ST_GAP;
                        r_ie      <= 1'b0;
                        r_gap_cnt <= '0;
                        r_aborted <= 1'b1;
                    end else begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                        if (w_bit_wrap) begin
                            r_bit_cyc <= '0;
                            if (w_word_wrap) begin
                                r_bit_idx <= IDX_MAX;
                                if (r_word_cnt < WORD_LAST) begin
                                    r_word_cnt <= r_word_cnt + 1'b1;
                                    r_pop      <= r_sel ? 2'b10 : 2'b01;
                                end
                            end else begin
                                r_bit_idx <= r_bit_idx - 1'b1;
                            end
                        end else begin
                            r_bit_cyc <= r_bit_cyc + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ie    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign interrupt_enable = r_ie;
    assign ch_sel           = r_sel;
    assign ch_pop           = r_pop;
    assign bit_idx          = r_bit_idx;
    assign busy             = r_busy;
    assign aborted          = r_aborted;

`ifdef RPI_IRQ_SCHED_OVF_EN
    // A saturated level on a source that is not currently being drained is an overflow.
    logic [1:0] r_ovf;
    logic [1:0] w_full;
    logic [1:0] w_draining;

    assign w_full[0]     = (ch0_level == {LEVEL_W{1'b1}});
    assign w_full[1]     = (ch1_level == {LEVEL_W{1'b1}});
    assign w_draining[0] = (r_state == ST_BURST) && !r_sel;
    assign w_draining[1] = (r_state == ST_BURST) && r_sel;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_ovf <= 2'b00;
        end else begin
            r_ovf <= r_ovf | (w_full & ~w_draining);
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
